// File: rtl/fpu_mc_sequencer_pkg.sv
// Shared definitions for the multi-cycle FPU sequencer: op encodings,
// canonical quiet-NaN patterns and the sequencer state type.
package fpu_mc_sequencer_pkg;

    localparam logic OP_DIV  = 1'b0;
    localparam logic OP_SQRT = 1'b1;

    localparam logic [31:0] QNAN32 = 32'h7FC0_0000;
    localparam logic [63:0] QNAN64 = 64'h7FF8_0000_0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        GAP  = 2'd3
    } state_t;

    function automatic logic [63:0] canonical_nan(input int unsigned flen);
        if (flen == 64) begin
            canonical_nan = QNAN64;
        end else begin
            canonical_nan = {32'h0000_0000, QNAN32};
        end
    endfunction

endpackage

// File: rtl/fpu_mc_sequencer_if.sv
// Issue, execution-unit and writeback signals of the sequencer, grouped
// so the core side and the sequencer side share one bundle.
interface fpu_mc_sequencer_if #(
    parameter int FLEN = 32
);
    logic            issueValid_i;
    logic            issueReady_o;
    logic            issueOp_i;
    logic [2:0]      rm_i;
    logic [4:0]      rd_i;
    logic [FLEN-1:0] rs1_i;
    logic [FLEN-1:0] rs2_i;
    logic            divEnable_o;
    logic            divReady_i;
    logic [FLEN-1:0] divResult_i;
    logic            sqrtEnable_o;
    logic            sqrtReady_i;
    logic [FLEN-1:0] sqrtResult_i;
    logic [FLEN-1:0] opRs1_o;
    logic [FLEN-1:0] opRs2_o;
    logic [2:0]      opRm_o;
    logic            flush_i;
    logic            wbValid_o;
    logic            wbReady_i;
    logic [FLEN-1:0] wbData_o;
    logic [4:0]      wbRd_o;
    logic            busy_o;
    logic            timeout_o;

    modport slave (
        input  issueValid_i, issueOp_i, rm_i, rd_i, rs1_i, rs2_i,
        input  divReady_i, divResult_i, sqrtReady_i, sqrtResult_i,
        input  flush_i, wbReady_i,
        output issueReady_o, divEnable_o, sqrtEnable_o,
        output opRs1_o, opRs2_o, opRm_o,
        output wbValid_o, wbData_o, wbRd_o, busy_o, timeout_o
    );

    modport master (
        output issueValid_i, issueOp_i, rm_i, rd_i, rs1_i, rs2_i,
        output divReady_i, divResult_i, sqrtReady_i, sqrtResult_i,
        output flush_i, wbReady_i,
        input  issueReady_o, divEnable_o, sqrtEnable_o,
        input  opRs1_o, opRs2_o, opRm_o,
        input  wbValid_o, wbData_o, wbRd_o, busy_o, timeout_o
    );
endinterface

// File: rtl/fpu_mc_timer.sv
// RUN-phase cycle counter; terminal fires in the cycle whose increment
// brings the count up to TIMEOUT.
module fpu_mc_timer
    import fpu_mc_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 63
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_r;

    // Cycle counter: cleared on issue, advances only while enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign terminal = enable && (count_r == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fpu_mc_sequencer.sv
// Sequences one divide or square-root op through its multi-cycle unit and
// returns the result over a valid/ready writeback port.
module fpu_mc_sequencer
    import fpu_mc_sequencer_pkg::*;
#(
    parameter int FLEN    = 32,
    parameter int TIMEOUT = 63
) (
    input  logic               clk_i,
    input  logic               reset_i,
    fpu_mc_sequencer_if.slave  bus
);
    localparam logic [FLEN-1:0] QNAN_C = FLEN'(canonical_nan(FLEN));

    state_t          state_r, state_nx_s;
    logic            op_r, op_nx_s;
    logic [FLEN-1:0] rs1_r, rs2_r, wb_data_r;
    logic [2:0]      rm_r;
    logic [4:0]      rd_r;
    logic            div_en_r, sqrt_en_r, wb_valid_r, busy_r, issue_ready_r, timeout_r;
    logic            accept_s, capture_s, expire_s, unit_ready_s, terminal_s, run_s;

    // Only the unit that owns the latched op may complete it.
    assign unit_ready_s = (op_r == OP_SQRT) ? bus.sqrtReady_i : bus.divReady_i;
    assign run_s        = (state_r == RUN);

    fpu_mc_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk      (clk_i),
        .rst      (reset_i),
        .clear    (accept_s),
        .enable   (run_s),
        .terminal (terminal_s)
    );

    // Next-state decode; flush takes priority over completion and timeout.
    always_comb begin
        state_nx_s = state_r;
        op_nx_s    = op_r;
        accept_s   = 1'b0;
        capture_s  = 1'b0;
        expire_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.issueValid_i) begin
                    accept_s   = 1'b1;
                    op_nx_s    = bus.issueOp_i;
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (bus.flush_i) begin
                    state_nx_s = GAP;
                end else if (unit_ready_s) begin
                    capture_s  = 1'b1;
                    state_nx_s = HOLD;
                end else if (terminal_s) begin
                    expire_s   = 1'b1;
                    state_nx_s = HOLD;
                end else begin
                    state_nx_s = RUN;
                end
            end
            HOLD: begin
                if (bus.flush_i || bus.wbReady_i) begin
                    state_nx_s = GAP;
                end else begin
                    state_nx_s = HOLD;
                end
            end
            GAP:     state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Registered outputs derived from the upcoming state, plus operand/result latches.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            op_r          <= OP_DIV;
            rs1_r         <= '0;
            rs2_r         <= '0;
            rm_r          <= 3'd0;
            rd_r          <= 5'd0;
            wb_data_r     <= '0;
            div_en_r      <= 1'b0;
            sqrt_en_r     <= 1'b0;
            wb_valid_r    <= 1'b0;
            busy_r        <= 1'b0;
            issue_ready_r <= 1'b1;
            timeout_r     <= 1'b0;
        end else begin
            div_en_r      <= (state_nx_s == RUN) && (op_nx_s == OP_DIV);
            sqrt_en_r     <= (state_nx_s == RUN) && (op_nx_s == OP_SQRT);
            wb_valid_r    <= (state_nx_s == HOLD);
            busy_r        <= (state_nx_s != IDLE);
            issue_ready_r <= (state_nx_s == IDLE);
            if (accept_s) begin
                op_r      <= op_nx_s;
                rs1_r     <= bus.rs1_i;
                rs2_r     <= bus.rs2_i;
                rm_r      <= bus.rm_i;
                rd_r      <= bus.rd_i;
                timeout_r <= 1'b0;
            end else if (capture_s) begin
                wb_data_r <= (op_r == OP_SQRT) ? bus.sqrtResult_i : bus.divResult_i;
            end else if (expire_s) begin
                wb_data_r <= QNAN_C;
                timeout_r <= 1'b1;
            end else begin
                wb_data_r <= wb_data_r;
            end
        end
    end

    assign bus.issueReady_o = issue_ready_r;
    assign bus.divEnable_o  = div_en_r;
    assign bus.sqrtEnable_o = sqrt_en_r;
    assign bus.opRs1_o      = rs1_r;
    assign bus.opRs2_o      = rs2_r;
    assign bus.opRm_o       = rm_r;
    assign bus.wbValid_o    = wb_valid_r;
    assign bus.wbData_o     = wb_data_r;
    assign bus.wbRd_o       = rd_r;
    assign bus.busy_o       = busy_r;
    assign bus.timeout_o    = timeout_r;

endmodule

// File: tb/tb_fpu_mc_sequencer.sv
// Directed bench for fpu_mc_sequencer: table of divide/sqrt vectors plus
// hand sequences for timeout, writeback stall, flush and mid-RUN reset.
module tb_fpu_mc_sequencer;
    import fpu_mc_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpu_mc_sequencer_if #(.FLEN(32)) bus();

    fpu_mc_sequencer #(.FLEN(32), .TIMEOUT(63)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    typedef struct {
        logic        op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [2:0]  rm;
        logic [4:0]  rd;
        int          lat;
        logic [31:0] res;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[4];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        bus.issueValid_i = 1'b1;
        bus.issueOp_i    = v.op;
        bus.rs1_i        = v.rs1;
        bus.rs2_i        = v.rs2;
        bus.rm_i         = v.rm;
        bus.rd_i         = v.rd;
        step();
        check("run_div_en", 64'(bus.divEnable_o), 64'(v.op == OP_DIV));
        check("run_sqrt_en", 64'(bus.sqrtEnable_o), 64'(v.op == OP_SQRT));
        check("run_op_rs2", 64'(bus.opRs2_o), 64'(v.rs2));
        check("run_op_rm", 64'(bus.opRm_o), 64'(v.rm));
        check("run_busy", 64'(bus.busy_o), 64'd1);
        check("run_issue_ready", 64'(bus.issueReady_o), 64'd0);
        // Offer a different op while busy; it must not be taken.
        bus.rs1_i     = ~v.rs1;
        bus.rs2_i     = ~v.rs2;
        bus.issueOp_i = ~v.op;
        for (int k = 1; k <= v.lat; k++) begin
            if (k == 1) begin
                if (v.op == OP_DIV) begin
                    bus.sqrtReady_i  = 1'b1;
                    bus.sqrtResult_i = 32'hDEAD_BEEF;
                end else begin
                    bus.divReady_i  = 1'b1;
                    bus.divResult_i = 32'hDEAD_BEEF;
                end
            end
            if (k == v.lat) begin
                if (v.op == OP_DIV) begin
                    bus.divReady_i  = 1'b1;
                    bus.divResult_i = v.res;
                end else begin
                    bus.sqrtReady_i  = 1'b1;
                    bus.sqrtResult_i = v.res;
                end
            end
            step();
            bus.divReady_i   = 1'b0;
            bus.sqrtReady_i  = 1'b0;
            bus.divResult_i  = 32'hBAD0_0001;
            bus.sqrtResult_i = 32'hBAD0_0002;
            if (k < v.lat) begin
                check("run_en_held", 64'(bus.divEnable_o | bus.sqrtEnable_o), 64'd1);
                check("run_no_wb", 64'(bus.wbValid_o), 64'd0);
                check("run_op_rs1_stable", 64'(bus.opRs1_o), 64'(v.rs1));
            end
        end
        bus.issueValid_i = 1'b0;
        check("hold_wb_valid", 64'(bus.wbValid_o), 64'd1);
        check("hold_wb_data", 64'(bus.wbData_o), 64'(v.exp_data));
        check("hold_wb_rd", 64'(bus.wbRd_o), 64'(v.rd));
        check("hold_en_low", 64'(bus.divEnable_o | bus.sqrtEnable_o), 64'd0);
        check("hold_issue_ready", 64'(bus.issueReady_o), 64'd0);
        bus.wbReady_i = 1'b1;
        step();
        bus.wbReady_i = 1'b0;
        check("gap_wb_valid", 64'(bus.wbValid_o), 64'd0);
        check("gap_en_low", 64'(bus.divEnable_o | bus.sqrtEnable_o), 64'd0);
        check("gap_issue_ready", 64'(bus.issueReady_o), 64'd0);
        check("gap_busy", 64'(bus.busy_o), 64'd1);
        step();
        check("idle_issue_ready", 64'(bus.issueReady_o), 64'd1);
        check("idle_busy", 64'(bus.busy_o), 64'd0);
    endtask

    initial begin
        int cycles;
        vecs[0] = '{OP_DIV,  32'h40C0_0000, 32'h4000_0000, 3'd0, 5'd5,  4, 32'h4040_0000, 32'h4040_0000};
        vecs[1] = '{OP_SQRT, 32'h4080_0000, 32'h1234_5678, 3'd1, 5'd12, 3, 32'h4000_0000, 32'h4000_0000};
        vecs[2] = '{OP_DIV,  32'h3F80_0000, 32'h4080_0000, 3'd4, 5'd31, 1, 32'h3E80_0000, 32'h3E80_0000};
        vecs[3] = '{OP_SQRT, 32'h4110_0000, 32'h0000_0000, 3'd2, 5'd0,  7, 32'h4040_0000, 32'h4040_0000};

        bus.issueValid_i = 1'b0; bus.issueOp_i = 1'b0; bus.rm_i = 3'd0; bus.rd_i = 5'd0;
        bus.rs1_i = 32'd0; bus.rs2_i = 32'd0;
        bus.divReady_i = 1'b0; bus.divResult_i = 32'd0;
        bus.sqrtReady_i = 1'b0; bus.sqrtResult_i = 32'd0;
        bus.flush_i = 1'b0; bus.wbReady_i = 1'b0;
        rst = 1'b1;
        step();
        step();
        check("rst_div_en", 64'(bus.divEnable_o), 64'd0);
        check("rst_sqrt_en", 64'(bus.sqrtEnable_o), 64'd0);
        check("rst_wb_valid", 64'(bus.wbValid_o), 64'd0);
        check("rst_wb_data", 64'(bus.wbData_o), 64'd0);
        check("rst_wb_rd", 64'(bus.wbRd_o), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_timeout", 64'(bus.timeout_o), 64'd0);
        check("rst_op_rs1", 64'(bus.opRs1_o), 64'd0);
        rst = 1'b0;
        step();
        check("rst_issue_ready", 64'(bus.issueReady_o), 64'd1);

        for (int i = 0; i < 4; i++) begin
            run_vec(i);
        end

        // Timeout: no ready ever arrives.
        bus.issueValid_i = 1'b1; bus.issueOp_i = OP_DIV; bus.rd_i = 5'd7;
        bus.rs1_i = 32'h3F80_0000; bus.rs2_i = 32'h0000_0000;
        step();
        bus.issueValid_i = 1'b0;
        cycles = 0;
        while (bus.wbValid_o !== 1'b1 && cycles < 100) begin
            step();
            cycles++;
        end
        check("to_cycles", 64'(cycles), 64'd63);
        check("to_wb_data", 64'(bus.wbData_o), 64'h7FC0_0000);
        check("to_flag", 64'(bus.timeout_o), 64'd1);
        check("to_wb_rd", 64'(bus.wbRd_o), 64'd7);
        bus.wbReady_i = 1'b1;
        step();
        bus.wbReady_i = 1'b0;
        step();
        check("to_sticky", 64'(bus.timeout_o), 64'd1);

        // Writeback stall for 10 cycles; also clears the sticky timeout on issue.
        bus.issueValid_i = 1'b1; bus.issueOp_i = OP_DIV; bus.rd_i = 5'd9;
        bus.rs1_i = 32'h40C0_0000; bus.rs2_i = 32'h4000_0000;
        step();
        bus.issueValid_i = 1'b0;
        check("to_cleared", 64'(bus.timeout_o), 64'd0);
        step();
        bus.divReady_i = 1'b1; bus.divResult_i = 32'h4040_0000;
        step();
        bus.divReady_i = 1'b0; bus.divResult_i = 32'hBAD0_0003;
        for (int k = 0; k < 10; k++) begin
            check("stall_wb_valid", 64'(bus.wbValid_o), 64'd1);
            check("stall_wb_data", 64'(bus.wbData_o), 64'h4040_0000);
            check("stall_issue_ready", 64'(bus.issueReady_o), 64'd0);
            step();
        end
        bus.wbReady_i = 1'b1;
        step();
        bus.wbReady_i = 1'b0;
        step();

        // Flush arriving together with the divider's ready.
        bus.issueValid_i = 1'b1; bus.issueOp_i = OP_DIV; bus.rd_i = 5'd3;
        step();
        bus.issueValid_i = 1'b0;
        step();
        bus.flush_i = 1'b1; bus.divReady_i = 1'b1; bus.divResult_i = 32'h1111_1111;
        step();
        bus.flush_i = 1'b0; bus.divReady_i = 1'b0;
        check("flush_wb_valid", 64'(bus.wbValid_o), 64'd0);
        check("flush_en_low", 64'(bus.divEnable_o), 64'd0);
        check("flush_gap_busy", 64'(bus.busy_o), 64'd1);
        check("flush_gap_ready", 64'(bus.issueReady_o), 64'd0);
        step();
        check("flush_idle_ready", 64'(bus.issueReady_o), 64'd1);
        check("flush_idle_wb_valid", 64'(bus.wbValid_o), 64'd0);
        check("flush_wb_data_kept", 64'(bus.wbData_o), 64'h4040_0000);
        run_vec(0);

        // Asynchronous reset in the middle of a sqrt.
        bus.issueValid_i = 1'b1; bus.issueOp_i = OP_SQRT; bus.rd_i = 5'd17;
        bus.rs1_i = 32'h4080_0000;
        step();
        bus.issueValid_i = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("arst_sqrt_en", 64'(bus.sqrtEnable_o), 64'd0);
        check("arst_busy", 64'(bus.busy_o), 64'd0);
        check("arst_wb_data", 64'(bus.wbData_o), 64'd0);
        check("arst_wb_rd", 64'(bus.wbRd_o), 64'd0);
        check("arst_op_rs1", 64'(bus.opRs1_o), 64'd0);
        step();
        rst = 1'b0;
        step();
        check("arst_wb_valid", 64'(bus.wbValid_o), 64'd0);
        check("arst_issue_ready", 64'(bus.issueReady_o), 64'd1);
        run_vec(1);
        run_vec(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
